ldst_mem_bridge: RTL and testbench
==================================

# ldst_mem_bridge

Load/store bridge between the processor core's data port and a multi-cycle data memory with a request/ready/response handshake. Sits directly downstream of the core top level: consumes the core's load/store address, write strobe and write data, and produces the core's load data and global stall input. Holds the whole core pipeline stalled while a memory access is outstanding and returns read data registered.

## Interface
Parameters:
- ADDR, 32, address width (matches core ADDR)
- W_OPR, 32, data width (matches core W_OPR)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_i  in  1  core presents a load/store this cycle
- write_i  in  1  1 = store, 0 = load; valid with req_i
- addr_i  in  ADDR  access address
- wdata_i  in  W_OPR  store data
- rdata_o  out  W_OPR  load data to core (registered)
- stall_o  out  1  to core stall input; core holds req_i/write_i/addr_i/wdata_i stable while high
- mem_req_o  out  1  memory request valid
- mem_we_o  out  1  memory write enable, valid with mem_req_o
- mem_addr_o  out  ADDR  memory address
- mem_wdata_o  out  W_OPR  memory write data
- mem_ready_i  in  1  memory accepts request when mem_req_o & mem_ready_i
- mem_rvalid_i  in  1  read data valid (loads only)
- mem_rdata_i  in  W_OPR  read data

## Operation
- FSM states: IDLE, REQ, RWAIT, DONE.
- IDLE: req_i=1 -> stall_o=1 combinationally, capture write_i/addr_i/wdata_i, go REQ. req_i=0 -> stall_o=0.
- REQ: mem_req_o=1 with captured we/addr/wdata; stall_o=1. On mem_ready_i: load -> RWAIT, store -> DONE.
- RWAIT: stall_o=1; mem_req_o=0. On mem_rvalid_i: rdata_o <= mem_rdata_i, go DONE. mem_rvalid_i ignored in every other state.
- DONE: stall_o=0 for exactly one cycle (core advances on this edge); go IDLE. req_i in DONE is not sampled.
- rdata_o holds last load data until next load completes; stores do not change it.
- Reset: state IDLE, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; stall_o follows req_i combinationally. Reset mid-access abandons it; a late mem_rvalid_i is discarded.

## Timing
- Load, zero-wait memory (ready in first REQ cycle, rvalid next cycle): cycle0 IDLE stall, cycle1 REQ, cycle2 RWAIT, cycle3 DONE stall_o=0 with rdata_o valid -> 4 cycles per load.
- Store, zero-wait: IDLE, REQ, DONE -> 3 cycles.
- mem_req_o/we/addr/wdata remain stable while mem_req_o=1 and mem_ready_i=0 (no withdrawal).
- Memory guarantees mem_rvalid_i no earlier than the cycle after acceptance.
- Minimum back-to-back spacing: one IDLE cycle between accesses.

## Configuration
- LDST_WRITE_BUFFER_EN defined: one-entry posted write buffer. Store in IDLE with buffer empty -> captured into buffer, stall_o=0, no FSM transition; buffer drains on the memory port in background (mem_req_o from the buffer). Store with buffer full -> stall until drained, then post. Load with buffer non-empty -> stall until drained, then normal load sequence (preserves ordering). A load is never serviced from the buffer.
- Not defined: every store runs the blocking IDLE/REQ/DONE sequence; no buffer logic.

## Structure
- State encoding and handshake constants go in the shared params include alongside WORD/ADDR/W_OPR.
- One sub-module, ldst_write_buffer (entry register, full flag, drain handshake), instantiated only under LDST_WRITE_BUFFER_EN.

## Test plan
- Load addr 0x10, memory ready immediately, rvalid one cycle later with 0xDEADBEEF -> stall_o high 3 cycles, low in DONE, rdata_o=0xDEADBEEF.
- Store addr 0x20 data 0x1234, mem_ready_i held low 4 cycles -> mem_req_o/addr/wdata stable 5 cycles, mem_we_o=1, stall released one cycle after acceptance.
- Reset deasserted-to-asserted during RWAIT, then rvalid pulse -> all outputs reset values, rdata_o stays 0, FSM IDLE.
- Back-to-back loads 0x0 then 0x4 returning 0xA, 0xB -> rdata_o 0xA then 0xB, exactly one IDLE cycle between.
- With LDST_WRITE_BUFFER_EN: store 0x30 then immediate load 0x30, memory ready after 2 cycles -> store no stall, load stalls until store accepted, memory sees write before read.

Source files
------------

// File: rtl/ldst_mem_bridge_pkg.sv
// Shared definitions for the load/store memory bridge: widths, FSM state encoding
// and memory handshake constants.
package ldst_mem_bridge_pkg;

    localparam int WORD          = 32;
    localparam int ADDR_DEFAULT  = 32;
    localparam int W_OPR_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } ldst_state_e;

    localparam logic MEM_WE_LOAD  = 1'b0;
    localparam logic MEM_WE_STORE = 1'b1;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/ldst_mem_bridge_write_buffer.sv
// One-entry posted write buffer for ldst_mem_bridge; drains its entry on the memory
// port in the background. Only instantiated when LDST_WRITE_BUFFER_EN is defined.
module ldst_write_buffer
    import ldst_mem_bridge_pkg::*;
#(
    parameter int ADDR  = ADDR_DEFAULT,
    parameter int W_OPR = W_OPR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [ADDR-1:0]  push_addr,
    input  logic [W_OPR-1:0] push_wdata,
    input  logic             mem_ready,
    output logic             full,
    output logic [ADDR-1:0]  entry_addr,
    output logic [W_OPR-1:0] entry_wdata
);

    logic             full_r;
    logic [ADDR-1:0]  addr_r;
    logic [W_OPR-1:0] wdata_r;

    // Entry capture and drain; a push only ever arrives while the entry is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r  <= 1'b0;
            addr_r  <= {ADDR{1'b0}};
            wdata_r <= {W_OPR{1'b0}};
        end else if (push) begin
            full_r  <= 1'b1;
            addr_r  <= push_addr;
            wdata_r <= push_wdata;
        end else if (hs_fire(full_r, mem_ready)) begin
            full_r  <= 1'b0;
        end
    end

    assign full        = full_r;
    assign entry_addr  = addr_r;
    assign entry_wdata = wdata_r;

endmodule

// File: rtl/ldst_mem_bridge.sv
// Load/store bridge: stalls the core while a multi-cycle memory access is outstanding.
// Optional posted write buffer enabled with `define LDST_WRITE_BUFFER_EN.
module ldst_mem_bridge
    import ldst_mem_bridge_pkg::*;
#(
    parameter int ADDR  = ADDR_DEFAULT,
    parameter int W_OPR = W_OPR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,
    input  logic             write_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic [W_OPR-1:0] wdata_i,
    output logic [W_OPR-1:0] rdata_o,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic [W_OPR-1:0] mem_wdata_o,
    input  logic             mem_ready_i,
    input  logic             mem_rvalid_i,
    input  logic [W_OPR-1:0] mem_rdata_i
);

    ldst_state_e      state_r;
    ldst_state_e      state_s;
    logic             stall_s;
    logic             start_s;
    logic             post_s;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [ADDR-1:0]  mem_addr_r;
    logic [W_OPR-1:0] mem_wdata_r;
    logic [W_OPR-1:0] rdata_r;

`ifdef LDST_WRITE_BUFFER_EN
    logic             buf_full_s;
    logic [ADDR-1:0]  buf_addr_s;
    logic [W_OPR-1:0] buf_wdata_s;

    ldst_write_buffer #(
        .ADDR  (ADDR),
        .W_OPR (W_OPR)
    ) u_write_buffer (
        .clk         (clk),
        .reset       (reset),
        .push        (post_s),
        .push_addr   (addr_i),
        .push_wdata  (wdata_i),
        .mem_ready   (mem_ready_i),
        .full        (buf_full_s),
        .entry_addr  (buf_addr_s),
        .entry_wdata (buf_wdata_s)
    );
`endif

    // Next-state and stall decode; the buffer is always empty while the FSM is busy.
    always_comb begin
        state_s = state_r;
        stall_s = 1'b0;
        start_s = 1'b0;
        post_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_i) begin
`ifdef LDST_WRITE_BUFFER_EN
                    if (buf_full_s) begin
                        stall_s = 1'b1;
                    end else if (write_i) begin
                        post_s  = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        start_s = 1'b1;
                        state_s = ST_REQ;
                    end
`else
                    stall_s = 1'b1;
                    start_s = 1'b1;
                    state_s = ST_REQ;
`endif
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (hs_fire(mem_req_r, mem_ready_i)) begin
                    state_s = (mem_we_r == MEM_WE_STORE) ? ST_DONE : ST_RWAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_RWAIT: begin
                stall_s = 1'b1;
                if (mem_rvalid_i) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RWAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory request registers: captured on access start, held until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= MEM_WE_LOAD;
            mem_addr_r  <= {ADDR{1'b0}};
            mem_wdata_r <= {W_OPR{1'b0}};
        end else if (start_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= write_i;
            mem_addr_r  <= addr_i;
            mem_wdata_r <= wdata_i;
        end else if (state_r == ST_REQ && mem_ready_i) begin
            mem_req_r   <= 1'b0;
        end
    end

    // Load data register; rvalid outside RWAIT (e.g. after a reset) is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= {W_OPR{1'b0}};
        end else if (state_r == ST_RWAIT && mem_rvalid_i) begin
            rdata_r <= mem_rdata_i;
        end
    end

    assign stall_o = stall_s;
    assign rdata_o = rdata_r;

`ifdef LDST_WRITE_BUFFER_EN
    assign mem_req_o   = mem_req_r | buf_full_s;
    assign mem_we_o    = buf_full_s ? MEM_WE_STORE : mem_we_r;
    assign mem_addr_o  = buf_full_s ? buf_addr_s : mem_addr_r;
    assign mem_wdata_o = buf_full_s ? buf_wdata_s : mem_wdata_r;
`else
    assign mem_req_o   = mem_req_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
`endif

endmodule

// File: tb/tb_ldst_mem_bridge.sv
// Self-checking bench for ldst_mem_bridge: vector table plus hand sequences, with a
// memory responder that checks each request against a scoreboard queue.
module tb_ldst_mem_bridge;

`ifdef LDST_WRITE_BUFFER_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rd;
        int          vd;
        logic [31:0] mem_rdata;
        int          exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0;
    logic        write_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    mem_txn_t    exp_mem_q[$];
    logic [31:0] rdata_q[$];
    int          ready_delay_g = 0;
    int          rvalid_delay_g = 0;
    bit          late_rvalid_g = 1'b0;

    int          wait_cnt = 0;
    int          rd_cnt = 0;
    bit          rd_pending = 1'b0;
    logic [31:0] rd_data = 32'd0;
    mem_txn_t    head;

    vec_t vecs[6];

    ldst_mem_bridge #(.ADDR(32), .W_OPR(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req_i),
        .write_i      (write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: checks each request cycle against the scoreboard head.
    always @(negedge clk) begin
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        if (!reset) begin
            wait_cnt   = 0;
            rd_pending = 1'b0;
        end else begin
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rd_data;
                    rd_pending   = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end
            if (mem_req_o) begin
                if (exp_mem_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mem_unexpected: got addr %h we %b expected no request", mem_addr_o, mem_we_o);
                end else begin
                    head = exp_mem_q[0];
                    check("mem_we", {31'd0, mem_we_o}, {31'd0, head.we});
                    check("mem_addr", mem_addr_o, head.addr);
                    if (head.we) check("mem_wdata", mem_wdata_o, head.wdata);
                    if (wait_cnt >= ready_delay_g) begin
                        mem_ready_i = 1'b1;
                        wait_cnt    = 0;
                        void'(exp_mem_q.pop_front());
                        if (!head.we) begin
                            rd_pending = 1'b1;
                            rd_cnt     = rvalid_delay_g;
                            rd_data    = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'hXXXX_XXXX;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end
        end
        if (late_rvalid_g) begin
            mem_rvalid_i  = 1'b1;
            mem_rdata_i   = 32'hBAD0_BAD0;
            late_rvalid_g = 1'b0;
        end
    end

    // Drives one access starting in IDLE and returns in the DONE cycle (stall low).
    task automatic run_access(input vec_t v, input string tag);
        int stalls;
        bit done;
        ready_delay_g  = v.rd;
        rvalid_delay_g = v.vd;
        req_i   = 1'b1;
        write_i = v.we;
        addr_i  = v.addr;
        wdata_i = v.wdata;
        exp_mem_q.push_back('{we: v.we, addr: v.addr, wdata: v.wdata});
        if (!v.we) rdata_q.push_back(v.mem_rdata);
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            if (stall_o) begin
                stalls++;
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, required release", tag, stalls);
        end
        check({tag, "_stall_cycles"}, stalls, v.exp_stall);
        check({tag, "_rdata"}, rdata_o, v.exp_rdata);
    endtask

    task automatic wait_idle(input string tag);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            @(negedge clk);
            #1;
            idle = !mem_req_o && (exp_mem_q.size() == 0);
        end
        if (!idle) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: memory request still pending, required idle", tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         0, 0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_1234, 4, 0, 32'h0,         (WB_EN ? 0 : 6), 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'h0,         2, 1, 32'h55AA_55AA, 6, 32'h55AA_55AA};
        vecs[3] = '{1'b1, 32'h0000_0048, 32'hCAFE_F00D, 0, 0, 32'h0,         (WB_EN ? 0 : 2), 32'h55AA_55AA};
        vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1, 3, 32'h0000_0000, 7, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0000_0008, 32'h0,         0, 0, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF};

        // Reset state; stall follows req_i combinationally during reset.
        #3;
        reset = 1'b0;
        req_i = 1'b1;
        #1;
        check("reset_stall_req1", {31'd0, stall_o}, 32'd1);
        req_i = 1'b0;
        #1;
        check("reset_stall_req0", {31'd0, stall_o}, 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we_o}, 32'd0);
        check("reset_mem_addr", mem_addr_o, 32'd0);
        check("reset_mem_wdata", mem_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table-driven accesses, each followed by an idle gap.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            run_access(vecs[i], $sformatf("vec%0d", i));
            @(negedge clk);
            req_i = 1'b0;
            wait_idle($sformatf("vec%0d", i));
        end

        // Back-to-back loads with only the mandatory IDLE cycle between them.
        @(negedge clk);
        run_access('{1'b0, 32'h0, 32'h0, 0, 0, 32'h0000_000A, 3, 32'h0000_000A}, "b2b_first");
        @(negedge clk);
        run_access('{1'b0, 32'h4, 32'h0, 0, 0, 32'h0000_000B, 3, 32'h0000_000B}, "b2b_second");
        @(negedge clk);
        req_i = 1'b0;
        wait_idle("b2b");

        // Reset during RWAIT, then a stale rvalid pulse.
        @(negedge clk);
        ready_delay_g  = 0;
        rvalid_delay_g = 20;
        req_i   = 1'b1;
        write_i = 1'b0;
        addr_i  = 32'h0000_0050;
        exp_mem_q.push_back('{we: 1'b0, addr: 32'h0000_0050, wdata: 32'h0});
        rdata_q.push_back(32'h0000_0099);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req_i = 1'b0;
        #1;
        check("rst_mid_rdata", rdata_o, 32'd0);
        check("rst_mid_stall", {31'd0, stall_o}, 32'd0);
        check("rst_mid_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mid_mem_addr", mem_addr_o, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        late_rvalid_g = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("late_rvalid_rdata", rdata_o, 32'd0);
        check("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
        check("late_rvalid_mem_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        run_access('{1'b0, 32'h60, 32'h0, 0, 0, 32'h0000_1357, 3, 32'h0000_1357}, "post_reset");
        @(negedge clk);
        req_i = 1'b0;
        wait_idle("post_reset");

`ifdef LDST_WRITE_BUFFER_EN
        // Posted store then immediate load to the same address; write must reach memory first.
        @(negedge clk);
        ready_delay_g = 2;
        req_i   = 1'b1;
        write_i = 1'b1;
        addr_i  = 32'h0000_0030;
        wdata_i = 32'h0000_0077;
        exp_mem_q.push_back('{we: 1'b1, addr: 32'h0000_0030, wdata: 32'h0000_0077});
        #1;
        check("wb_post_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        run_access('{1'b0, 32'h30, 32'h0, 2, 0, 32'h0000_0077, 8, 32'h0000_0077}, "wb_load");
        @(negedge clk);
        req_i = 1'b0;
        wait_idle("wb_load");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
